// File: rtl/apuf_pkg.sv
// Shared types and constants for the arbiter PUF challenge/response sequencer.
package apuf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        LAUNCH,
        SETTLE,
        SAMPLE,
        RELAX,
        VOTE,
        OUT
    } state_t;

    localparam logic [31:0] LFSR_MASK     = 32'h8020_0003;
    localparam logic [31:0] LFSR_ZERO_SUB = 32'h0000_0001;

endpackage

// File: rtl/apuf_lfsr32.sv
// 32-bit right-shifting Galois LFSR with seed load and enable-gated advance.
module apuf_lfsr32
    import apuf_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        adv,
    output logic        out_bit
);

    logic [31:0] lfsr;

    // An all-zero state would lock the register, so a zero seed is substituted.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= '0;
        end else if (load) begin
            lfsr <= (seed == '0) ? LFSR_ZERO_SUB : seed;
        end else if (adv) begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
        end
    end

    assign out_bit = lfsr[0];

endmodule

// File: rtl/apuf_crp_sequencer.sv
// Arbiter PUF driver: LFSR challenges, repeated races, majority vote, CRP handshake.
module apuf_crp_sequencer
    import apuf_pkg::*;
#(
    parameter int unsigned CHAL_W     = 243,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned N_REPEAT   = 5,
    parameter int unsigned CONF_W     = $clog2(N_REPEAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       num_crp,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic [CHAL_W-1:0] chal,
    output logic              race_x,
    output logic              race_y,
    input  logic              puf_q,
    output logic              crp_valid,
    input  logic              crp_ready,
    output logic              crp_resp,
    output logic [CONF_W-1:0] crp_conf,
    output logic              done
);

    localparam int unsigned CNT_MAX = (CHAL_W > SETTLE_CYC) ? CHAL_W : SETTLE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state;
    logic [CNT_W-1:0]  step_cnt;
    logic [CONF_W-1:0] race_cnt;
    logic [CONF_W-1:0] vote_cnt;
    logic [15:0]       rem_cnt;
    logic              q_s1;
    logic              q_s2;
    logic              lfsr_load;
    logic              lfsr_adv;
    logic              lfsr_bit;

    assign lfsr_load = (state == IDLE) && start;
    assign lfsr_adv  = (state == FILL);

    apuf_lfsr32 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .seed    (seed),
        .adv     (lfsr_adv),
        .out_bit (lfsr_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            q_s1 <= 1'b0;
            q_s2 <= 1'b0;
        end else begin
            q_s1 <= puf_q;
            q_s2 <= q_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step_cnt  <= '0;
            race_cnt  <= '0;
            vote_cnt  <= '0;
            rem_cnt   <= '0;
            chal      <= '0;
            race_x    <= 1'b0;
            race_y    <= 1'b0;
            crp_valid <= 1'b0;
            crp_resp  <= 1'b0;
            crp_conf  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rem_cnt  <= num_crp;
                        busy     <= 1'b1;
                        step_cnt <= '0;
                        // A zero-length run parks in OUT with nothing to hand over
                        // so that done lands one cycle after the start edge.
                        state    <= (num_crp == '0) ? OUT : FILL;
                    end
                end
                FILL: begin
                    chal <= {chal[CHAL_W-2:0], lfsr_bit};
                    if (step_cnt == CNT_W'(CHAL_W - 1)) begin
                        step_cnt <= '0;
                        vote_cnt <= '0;
                        race_cnt <= '0;
                        state    <= LAUNCH;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                LAUNCH: begin
                    race_x   <= 1'b1;
                    race_y   <= 1'b1;
                    step_cnt <= '0;
                    state    <= SETTLE;
                end
                SETTLE: begin
                    if (step_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        step_cnt <= '0;
                        state    <= SAMPLE;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    vote_cnt <= vote_cnt + CONF_W'(q_s2);
                    race_cnt <= race_cnt + 1'b1;
                    race_x   <= 1'b0;
                    race_y   <= 1'b0;
                    step_cnt <= '0;
                    state    <= RELAX;
                end
                RELAX: begin
                    if (step_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        step_cnt <= '0;
                        state    <= (race_cnt == CONF_W'(N_REPEAT)) ? VOTE : LAUNCH;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                VOTE: begin
                    crp_conf  <= vote_cnt;
                    crp_resp  <= (vote_cnt > CONF_W'(N_REPEAT / 2));
                    crp_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (rem_cnt == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (crp_valid && crp_ready) begin
                        crp_valid <= 1'b0;
                        rem_cnt   <= rem_cnt - 1'b1;
                        step_cnt  <= '0;
                        if (rem_cnt == 16'd1) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apuf_crp_sequencer.md
# apuf_crp_sequencer

Challenge/response driver for the arbiter PUF chain. Generates pseudo-random challenges from a seeded LFSR, holds each challenge stable on the PUF `Chal` bus and fires the race by raising `X`/`Y` together. It then samples the arbiter flip-flop output `out_Q` through a synchronizer, majority-votes repeated races, and hands each challenge/response pair (CRP) to a downstream collector over a valid/ready handshake.

## Interface
Parameters:
- `CHAL_W`, 243: challenge width; matches PUF stage count.
- `SETTLE_CYC`, 8: cycles the race is held high before sampling, and also held low before relaunch; minimum 3.
- `N_REPEAT`, 5: races per challenge; must be odd, minimum 1.
- `CONF_W`, $clog2(N_REPEAT+1): width of the vote count.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `num_crp` in 16: number of CRPs to produce; latched on start.
- `seed` in 32: LFSR seed; latched on start.
- `busy` out 1: high from start acceptance until return to IDLE.
- `chal` out CHAL_W: drives PUF `Chal`.
- `race_x`, `race_y` out 1 each: drive PUF `X`/`Y`; registered and always equal.
- `puf_q` in 1: PUF `out_Q`; asynchronous to `clk`.
- `crp_valid` out 1: CRP available; qualifies `chal`, `crp_resp`, `crp_conf`.
- `crp_ready` in 1: downstream accept.
- `crp_resp` out 1: majority-voted response bit.
- `crp_conf` out CONF_W: number of races that returned 1.
- `done` out 1: one-cycle pulse when the run completes.

## Operation
- States: IDLE, FILL, LAUNCH, SETTLE, SAMPLE, RELAX, VOTE, OUT.
- IDLE: on `start`, latch `num_crp` into a remaining-count and `seed` into the LFSR. A seed of 0 is replaced by 0x00000001. If `num_crp`=0, go straight to done (next bullet). Otherwise go to FILL.
- Done: `done`=1 for one cycle, then IDLE.
- LFSR: 32-bit Galois, right-shifting, feedback mask 0x80200003 applied when the output bit `lfsr[0]`=1. It advances only in FILL.
- FILL: CHAL_W cycles. Each cycle `chal <= {chal[CHAL_W-2:0], lfsr[0]}` and the LFSR advances. Then clear the vote counter and go to LAUNCH.
- LAUNCH: 1 cycle. Sets `race_x`=`race_y`=1.
- SETTLE: SETTLE_CYC cycles, race lines held high.
- SAMPLE: 1 cycle. Add the synchronized `puf_q` (2-flop synchronizer) to the vote counter. Race lines drop to 0 at exit.
- RELAX: SETTLE_CYC cycles with race lines low. Then go to LAUNCH if fewer than N_REPEAT races are done, else VOTE.
- VOTE: 1 cycle. `crp_conf` = count; `crp_resp` = (count > N_REPEAT/2). Go to OUT.
- OUT: `crp_valid`=1. On `crp_valid && crp_ready`, decrement the remaining-count. If it was 1, go to done; else go to FILL.
- `chal` changes only in FILL, so it is stable from the end of FILL through the OUT handshake.
- `start` is ignored while `busy`.
- `rst` (any state, mid-race included): state IDLE; all outputs 0 (`chal`, `race_x/y`, `crp_*`, `busy`, `done`); LFSR, counters and synchronizer cleared.

## Timing
- Cycle 0 is the edge on which `start` is sampled.
- Per race: 2*SETTLE_CYC+2 cycles.
- Latency from the start edge to `crp_valid` rising: CHAL_W + N_REPEAT*(2*SETTLE_CYC+2) + 1 cycles.
- Subsequent CRPs: the same latency, measured from the handshake edge.
- `done` rises 1 cycle after the final handshake, or 1 cycle after start when `num_crp`=0.
- `busy` rises the cycle after the start edge and falls together with `done`.
- `race_x`/`race_y` are high for exactly SETTLE_CYC+1 cycles per race and never toggle outside LAUNCH/SETTLE/SAMPLE.

## Structure
- Shared package `apuf_pkg` holds:
  - the state enum;
  - the LFSR mask 0x80200003;
  - the zero-seed substitute 0x00000001.
- One natural sub-module: `apuf_lfsr32`, covering seed load, zero-seed substitution and enable-gated advance.
- The synchronizer is two inline flops.

## Test plan
- Reset: assert `rst` for 3 cycles → all outputs 0, state IDLE; `start` during reset is ignored.
- Single CRP with CHAL_W=8, SETTLE_CYC=4, N_REPEAT=3, `puf_q` tied 1, `crp_ready`=1 → `crp_valid` at cycle 39, `crp_resp`=1, `crp_conf`=3, `chal` matches the LFSR model for seed 1, `done` at cycle 40.
- Voting: `puf_q` races 1,0,1 → resp 1, conf 2; races 0,0,1 → resp 0, conf 1. Sample on the SAMPLE cycle plus the synchronizer offset.
- Backpressure with `num_crp`=3: hold `crp_ready` low for 20 cycles on each CRP → `crp_valid`, `chal` and `crp_*` stable and race lines quiet; exactly 3 handshakes, then one `done` pulse.
- Edge requests: `num_crp`=0 → `done` at cycle 1, no race activity; a second `start` while busy has no effect; seed 0 → output identical to seed 1.
- Reset mid-SETTLE → race lines and `busy` 0 on the next edge; a fresh start then reproduces the same first challenge.
